// File: rtl/vga_pkg.sv
// vga_pkg: shared timing defaults and pixel types for the VGA transmitter.
//   DEF_*        : 640x480 @ 60 Hz timing defaults (pixels / lines)
//   H_TOT/V_TOT  : total pixels per line / lines per frame for the defaults
//   H_VIS_START  : first visible h_cnt value; V_VIS_START: first visible v_cnt value
//   rgb444_t     : 12-bit {r[3:0], g[3:0], b[3:0]} pixel
//   bar_rgb()    : colour-bar pattern helper used by the optional test pattern
package vga_pkg;

  localparam int unsigned DEF_CLK_DIV = 4;
  localparam int unsigned DEF_H_SYNC  = 96;
  localparam int unsigned DEF_H_BP    = 48;
  localparam int unsigned DEF_H_ACT   = 640;
  localparam int unsigned DEF_H_FP    = 16;
  localparam int unsigned DEF_V_SYNC  = 2;
  localparam int unsigned DEF_V_BP    = 33;
  localparam int unsigned DEF_V_ACT   = 480;
  localparam int unsigned DEF_V_FP    = 10;

  localparam int unsigned H_TOT = DEF_H_SYNC + DEF_H_BP + DEF_H_ACT + DEF_H_FP;
  localparam int unsigned V_TOT = DEF_V_SYNC + DEF_V_BP + DEF_V_ACT + DEF_V_FP;

  localparam int unsigned H_VIS_START = DEF_H_SYNC + DEF_H_BP;
  localparam int unsigned V_VIS_START = DEF_V_SYNC + DEF_V_BP;

  typedef logic [11:0] rgb444_t;

  // Each bar bit saturates one colour channel.
  function automatic rgb444_t bar_rgb(input logic [2:0] bar);
    return {{4{bar[2]}}, {4{bar[1]}}, {4{bar[0]}}};
  endfunction

endpackage

// File: rtl/vga_tick_gen.sv
// vga_tick_gen: pixel-tick divider.
//   clk  : system clock
//   rstn : asynchronous active-low reset
//   tick : high for one clk every CLK_DIV clks (on the clk where the divider wraps)
module vga_tick_gen #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk,
  input  logic rstn,
  output logic tick
);

  localparam int unsigned CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] DivMax = CW'(CLK_DIV - 1);

  logic [CW-1:0] div_q, div_d;

  always_comb begin
    div_d = (div_q == DivMax) ? '0 : div_q + 1'b1;
  end

  assign tick = (div_q == DivMax);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      div_q <= '0;
    end else begin
      div_q <= div_d;
    end
  end

endmodule

// File: rtl/vga_tx.sv
// vga_tx: 640x480 VGA transmitter (sync generator, pixel address issuer, RGB stage).
//   clk, rstn          : system clock, asynchronous active-low reset
//   test_en            : colour-bar override (only with VGA_TX_TEST_PATTERN_EN defined)
//   vgac_in            : pixel {r,g,b} for the address issued one tick earlier
//   rdn                : low while row_addr/col_addr point at a visible pixel
//   row_addr, col_addr : visible pixel address (0 while blanked)
//   r, g, b            : colour out, forced to 0 while de=0
//   hs, vs             : active-low syncs, aligned with de and rgb
//   de                 : data enable
//   frame_start        : one-clk pulse when a frame's first pixel position is entered
// Optional feature macro: VGA_TX_TEST_PATTERN_EN.
module vga_tx
  import vga_pkg::*;
#(
  parameter int unsigned CLK_DIV = DEF_CLK_DIV,
  parameter int unsigned H_SYNC  = DEF_H_SYNC,
  parameter int unsigned H_BP    = DEF_H_BP,
  parameter int unsigned H_ACT   = DEF_H_ACT,
  parameter int unsigned H_FP    = DEF_H_FP,
  parameter int unsigned V_SYNC  = DEF_V_SYNC,
  parameter int unsigned V_BP    = DEF_V_BP,
  parameter int unsigned V_ACT   = DEF_V_ACT,
  parameter int unsigned V_FP    = DEF_V_FP
) (
  input  logic        clk,
  input  logic        rstn,
`ifdef VGA_TX_TEST_PATTERN_EN
  input  logic        test_en,
`endif
  input  logic [11:0] vgac_in,
  output logic        rdn,
  output logic [8:0]  row_addr,
  output logic [9:0]  col_addr,
  output logic [3:0]  r,
  output logic [3:0]  g,
  output logic [3:0]  b,
  output logic        hs,
  output logic        vs,
  output logic        de,
  output logic        frame_start
);

  localparam int unsigned HTot = H_SYNC + H_BP + H_ACT + H_FP;
  localparam int unsigned VTot = V_SYNC + V_BP + V_ACT + V_FP;
  // One extra count of headroom so the visible-end bound always fits.
  localparam int unsigned HW = $clog2(HTot + 1);
  localparam int unsigned VW = $clog2(VTot + 1);

  localparam logic [HW-1:0] HLast     = HW'(HTot - 1);
  localparam logic [HW-1:0] HSyncEnd  = HW'(H_SYNC);
  localparam logic [HW-1:0] HVisStart = HW'(H_SYNC + H_BP);
  localparam logic [HW-1:0] HVisEnd   = HW'(H_SYNC + H_BP + H_ACT);
  localparam logic [VW-1:0] VLast     = VW'(VTot - 1);
  localparam logic [VW-1:0] VSyncEnd  = VW'(V_SYNC);
  localparam logic [VW-1:0] VVisStart = VW'(V_SYNC + V_BP);
  localparam logic [VW-1:0] VVisEnd   = VW'(V_SYNC + V_BP + V_ACT);

  logic tick;

  vga_tick_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_tick_gen (
    .clk (clk),
    .rstn(rstn),
    .tick(tick)
  );

  // Counters. run_q is clear after reset so that the first tick enters (0,0) as a
  // fresh frame start instead of stepping past it.
  logic [HW-1:0] h_cnt_q, h_cnt_d;
  logic [VW-1:0] v_cnt_q, v_cnt_d;
  logic          run_q, run_d;
  logic          fs_q, fs_d;

  always_comb begin
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    run_d   = run_q;
    fs_d    = 1'b0;
    if (tick) begin
      if (!run_q) begin
        run_d   = 1'b1;
        h_cnt_d = '0;
        v_cnt_d = '0;
        fs_d    = 1'b1;
      end else if (h_cnt_q == HLast) begin
        h_cnt_d = '0;
        if (v_cnt_q == VLast) begin
          v_cnt_d = '0;
          fs_d    = 1'b1;
        end else begin
          v_cnt_d = v_cnt_q + 1'b1;
        end
      end else begin
        h_cnt_d = h_cnt_q + 1'b1;
      end
    end
  end

  // Stage A: decoded from the position being entered, so it lines up with the counters.
  logic       rdn_q, rdn_d;
  logic [8:0] row_q, row_d;
  logic [9:0] col_q, col_d;
  logic       hs_a_q, hs_a_d;
  logic       vs_a_q, vs_a_d;
  logic       vis;

  always_comb begin
    vis    = (h_cnt_d >= HVisStart) && (h_cnt_d < HVisEnd) &&
             (v_cnt_d >= VVisStart) && (v_cnt_d < VVisEnd);
    rdn_d  = rdn_q;
    row_d  = row_q;
    col_d  = col_q;
    hs_a_d = hs_a_q;
    vs_a_d = vs_a_q;
    if (tick) begin
      rdn_d  = ~vis;
      col_d  = vis ? 10'(h_cnt_d - HVisStart) : '0;
      row_d  = vis ? 9'(v_cnt_d - VVisStart) : '0;
      hs_a_d = (h_cnt_d >= HSyncEnd);
      vs_a_d = (v_cnt_d >= VSyncEnd);
    end
  end

  // Stage B: captures the pixel returned for the stage-A address.
  rgb444_t src_rgb;
  rgb444_t rgb_q, rgb_d;
  logic    de_q, de_d;
  logic    hs_q, hs_d;
  logic    vs_q, vs_d;

`ifdef VGA_TX_TEST_PATTERN_EN
  assign src_rgb = test_en ? bar_rgb(col_q[9:7]) : vgac_in;
`else
  assign src_rgb = vgac_in;
`endif

  always_comb begin
    rgb_d = rgb_q;
    de_d  = de_q;
    hs_d  = hs_q;
    vs_d  = vs_q;
    if (tick) begin
      rgb_d = rdn_q ? '0 : src_rgb;
      de_d  = ~rdn_q;
      hs_d  = hs_a_q;
      vs_d  = vs_a_q;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
      run_q   <= 1'b0;
      fs_q    <= 1'b0;
      rdn_q   <= 1'b1;
      row_q   <= '0;
      col_q   <= '0;
      hs_a_q  <= 1'b0;
      vs_a_q  <= 1'b0;
      rgb_q   <= '0;
      de_q    <= 1'b0;
      hs_q    <= 1'b0;
      vs_q    <= 1'b0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
      run_q   <= run_d;
      fs_q    <= fs_d;
      rdn_q   <= rdn_d;
      row_q   <= row_d;
      col_q   <= col_d;
      hs_a_q  <= hs_a_d;
      vs_a_q  <= vs_a_d;
      rgb_q   <= rgb_d;
      de_q    <= de_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
    end
  end

  assign rdn         = rdn_q;
  assign row_addr    = row_q;
  assign col_addr    = col_q;
  assign r           = rgb_q[11:8];
  assign g           = rgb_q[7:4];
  assign b           = rgb_q[3:0];
  assign hs          = hs_q;
  assign vs          = vs_q;
  assign de          = de_q;
  assign frame_start = fs_q;

endmodule
